req_grant_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among NREQ single-bit requesters (the b0..b3-style strobes driven by our benches).
- Request-to-grant contract is the one the team checks with PSL: a request sampled at a posedge of clk while the resource is free yields a grant at the next posedge ({req} |=> gnt).
- Adds hold-until-release ownership, a maximum-hold timeout with forced handoff, and status outputs for bench checkers.

---
 rtl/req_grant_arbiter.sv | 121 ++++++++++++
 tb/tb_req_grant_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/req_grant_arbiter.sv
// Round-robin request/grant arbiter with hold-until-release ownership,
// a maximum-hold timeout with forced handoff, and registered status outputs.
module req_grant_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vld,
  output logic [IDW-1:0]  gnt_id,
  output logic            expire,
  output logic [CW-1:0]   hold_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            expire_q, expire_d;

  logic [IDW-1:0]  scan_base;
  logic            scan_hit;
  logic [IDW-1:0]  scan_idx;

  // Round-robin scan starting after scan_base; the base itself is only
  // eligible from IDLE, so a granting owner is never re-picked by the scan.
  always_comb begin
    int unsigned p;
    scan_base = (state_q == S_GRANT) ? owner_q : last_q;
    scan_hit  = 1'b0;
    scan_idx  = '0;
    p         = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      p = (32'(scan_base) + k) % NREQ;
      if (req[IDW'(p)] && ((k < NREQ) || (state_q == S_IDLE))) begin
        scan_hit = 1'b1;
        scan_idx = IDW'(p);
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    expire_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_hit) begin
          state_d = S_GRANT;
          owner_d = scan_idx;
          gnt_d   = NREQ'(1) << scan_idx;
          hold_d  = CW'(1);
        end
      end
      S_GRANT: begin
        if (!req[owner_q]) begin
          last_d = owner_q;
          if (scan_hit) begin
            owner_d = scan_idx;
            gnt_d   = NREQ'(1) << scan_idx;
            hold_d  = CW'(1);
          end else begin
            state_d = S_IDLE;
            owner_d = '0;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q == CW'(MAX_HOLD)) begin
          last_d   = owner_q;
          expire_d = 1'b1;
          hold_d   = CW'(1);
          if (scan_hit) begin
            owner_d = scan_idx;
            gnt_d   = NREQ'(1) << scan_idx;
          end
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= IDW'(NREQ - 1);
      owner_q  <= '0;
      gnt_q    <= '0;
      hold_q   <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      expire_q <= expire_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_vld  = (state_q == S_GRANT);
  assign gnt_id   = owner_q;
  assign expire   = expire_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Bench for req_grant_arbiter: directed scenarios plus random traffic,
// checked against an ownership-level reference model.
module tb_req_grant_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned MH   = 4;
  localparam int unsigned CW   = 4;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic            expire;
  logic [CW-1:0]   hold_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: owner index or -1 when free.
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_hold  = 0;
  int m_exp   = 0;

  int seen_ids[$];
  int prev_id = -1;

  req_grant_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MH), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_vld(gnt_vld),
    .gnt_id(gnt_id), .expire(expire), .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester found after 'start', looking at 'span' positions.
  function automatic int pick(input logic [NREQ-1:0] r, input int start, input int span);
    for (int k = 1; k <= span; k++) begin
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model(input logic r, input logic [NREQ-1:0] rq);
    int w;
    if (!r) begin
      m_owner = -1; m_last = NREQ - 1; m_hold = 0; m_exp = 0;
    end else if (m_owner < 0) begin
      m_exp = 0;
      w = pick(rq, m_last, NREQ);
      if (w >= 0) begin m_owner = w; m_hold = 1; end
    end else if (!rq[m_owner]) begin
      m_exp  = 0;
      m_last = m_owner;
      w = pick(rq, m_owner, NREQ - 1);
      if (w >= 0) begin m_owner = w; m_hold = 1; end
      else begin m_owner = -1; m_hold = 0; end
    end else if (m_hold == MH) begin
      m_exp  = 1;
      m_last = m_owner;
      m_hold = 1;
      w = pick(rq, m_owner, NREQ - 1);
      if (w >= 0) m_owner = w;
    end else begin
      m_exp = 0;
      m_hold++;
    end
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] rq);
    logic [NREQ-1:0] eg;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    @(posedge clk);
    model(r, rq);
    #1;
    eg = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    chk("gnt",      32'(gnt),      32'(eg));
    chk("gnt_vld",  32'(gnt_vld),  32'(m_owner >= 0));
    chk("gnt_id",   32'(gnt_id),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("hold_cnt", 32'(hold_cnt), 32'(m_hold));
    chk("expire",   32'(expire),   32'(m_exp));
    chk("onehot0",  32'($onehot0(gnt)), 32'd1);
    if (gnt_vld && (32'(gnt_id) != 32'(prev_id))) seen_ids.push_back(int'(gnt_id));
    prev_id = gnt_vld ? int'(gnt_id) : -1;
  endtask

  initial begin
    int exp_rr[6];
    logic [NREQ-1:0] rq;
    exp_rr = '{0, 1, 3, 0, 1, 3};
    rst_n = 1'b0;
    req   = '0;

    // Reset with all requests high
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1111);

    // Single-request latency and release
    step(1'b1, 4'b0001);
    chk("lat_gnt", 32'(gnt), 32'h1);
    step(1'b1, 4'b0000);
    chk("rel_gnt", 32'(gnt), 32'h0);

    // Round-robin: owner drops its bit after 2 cycles of ownership
    step(1'b0, 4'b0000);
    seen_ids.delete();
    for (int i = 0; i < 20; i++) begin
      rq = 4'b1011;
      if (m_owner >= 0 && m_hold == 2) rq[m_owner] = 1'b0;
      step(1'b1, rq);
    end
    chk("rr_len", 32'(seen_ids.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      if (i < seen_ids.size()) chk("rr_order", 32'(seen_ids[i]), 32'(exp_rr[i]));

    // Timeout handoff between 0 and 2
    step(1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0101);
      chk("to_hold", 32'(hold_cnt), 32'(i + 1));
    end
    step(1'b1, 4'b0101);
    chk("to_gnt2", 32'(gnt), 32'h4);
    chk("to_exp",  32'(expire), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0101);
    step(1'b1, 4'b0101);
    chk("to_back0", 32'(gnt), 32'h1);

    // Lone requester timeout keeps the grant
    step(1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0010);
      chk("lone_gnt", 32'(gnt), 32'h2);
    end

    // Reset mid-grant
    step(1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1000);
    chk("mid_hold", 32'(hold_cnt), 32'd3);
    step(1'b0, 4'b1000);
    chk("mid_clr", 32'(gnt), 32'h0);
    step(1'b1, 4'b1001);
    chk("mid_next", 32'(gnt), 32'h1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rq = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && m_owner >= 0) rq[m_owner] = 1'b1;
      step(($urandom_range(0, 49) != 0), rq);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
